// File: rtl/if_fetch_stage.sv
// Small FIFO with a synchronous flush. It is used for both the instruction queue and the PC queue.
// Latency: a pushed word appears at the head in the cycle after the write edge.
// Backpressure: none. The caller's credit accounting keeps it from overflowing. A push to a full FIFO lands only when a pop happens in the same cycle.
module if_fetch_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   flush,
  input  logic                   push_vld,
  input  logic [W-1:0]           push_dat,
  input  logic                   pop_rdy,
  output logic [W-1:0]           head_dat,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  // Next pointers, count and storage. A flush empties the FIFO whatever else is requested.
  always_comb begin
    do_pop   = pop_rdy && (cnt_q != '0);
    do_push  = push_vld && ((cnt_q != FULL) || do_pop);
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign count    = cnt_q;
endmodule

// Instruction fetch front end. It owns the PC, issues in-order word requests, and queues the returned instructions with their PCs for decode.
// Latency: a request is issued at fire cycle T. Its response arrives at T+1 at the earliest and reaches decode one cycle after it arrives.
// Backpressure: a request is issued only while outstanding + drop + queued < BUF_DEPTH. id_ready=0 holds the head. imem_req_ready=0 holds the address.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2,
  parameter logic [31:0] NOP_INST  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc
);
  localparam int          CW      = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW:0] CREDITS = (CW+1)'(BUF_DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] out_q, out_d;    // requests fired whose response is still owed to the queue
  logic [CW-1:0] drop_q, drop_d;  // stale responses still to be discarded after a redirect
  logic [CW-1:0] iq_count, pq_count;
  logic [63:0]   iq_head;
  logic [31:0]   pq_head;
  logic [CW:0]   credit_used;
  logic          req_fire, resp_drop, resp_keep, id_pop;

  // Credit check, handshakes and the decode view of the queue head.
  always_comb begin
    credit_used    = {1'b0, out_q} + {1'b0, drop_q} + {1'b0, iq_count};
    imem_req_valid = rstn && !redirect_valid && (credit_used < CREDITS);
    imem_addr      = pc_q;
    req_fire       = imem_req_valid && imem_req_ready;
    resp_drop      = imem_resp_valid && (drop_q != '0);
    // A response is kept only when a recorded request address exists to pair with it.
    // A leftover response from before reset therefore finds the PC queue empty and is ignored.
    resp_keep      = imem_resp_valid && (drop_q == '0) && (pq_count != '0) && !redirect_valid;
    id_valid       = (iq_count != '0);
    id_pop         = id_valid && id_ready;
    id_inst        = id_valid ? iq_head[63:32] : NOP_INST;
    id_pc          = id_valid ? iq_head[31:0]  : 32'h0;
  end

  // Next PC and in-flight accounting. A redirect turns everything outstanding into drops.
  always_comb begin
    pc_d   = pc_q;
    out_d  = out_q;
    drop_d = drop_q;
    if (redirect_valid) begin
      pc_d   = redirect_pc & ~32'h3;
      out_d  = '0;
      drop_d = drop_q + out_q
             - CW'(imem_resp_valid && ((drop_q != '0) || (out_q != '0)));
    end else begin
      if (req_fire) pc_d = pc_q + 32'd4;
      out_d  = out_q + CW'(req_fire) - CW'(resp_keep);
      drop_d = drop_q - CW'(resp_drop);
    end
  end

  // PC and counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q   <= RESET_PC;
      out_q  <= '0;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      out_q  <= out_d;
      drop_q <= drop_d;
    end
  end

  if_fetch_fifo #(.W(32), .DEPTH(BUF_DEPTH)) u_pc_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .flush    (redirect_valid),
    .push_vld (req_fire),
    .push_dat (pc_q),
    .pop_rdy  (resp_keep),
    .head_dat (pq_head),
    .count    (pq_count)
  );

  if_fetch_fifo #(.W(64), .DEPTH(BUF_DEPTH)) u_inst_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .flush    (redirect_valid),
    .push_vld (resp_keep),
    .push_dat ({imem_resp_data, pq_head}),
    .pop_rdy  (id_pop),
    .head_dat (iq_head),
    .count    (iq_count)
  );
endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rstn;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid, id_ready;
  logic [31:0] id_inst, id_pc;

  always #5 clk = ~clk;

  if_fetch_stage #(.RESET_PC(RESET_PC), .BUF_DEPTH(2), .NOP_INST(NOP)) dut (
    .clk(clk), .rstn(rstn),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc)
  );

  int passed = 0, total = 0;
  int cyc = 0, fire_cnt = 0, pop_cnt = 0;
  logic [31:0] exp_req_pc, exp_dec_pc, last_fire_addr, last_pop_pc, hold_inst, hold_pc;
  bit hold_vld, mem_fixed, mem_hold;
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  // Memory contents: each address holds a word derived from the address itself.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // Reference model. Fetch walks addresses sequentially from the last target.
  // Decode sees the same sequence with no gaps or repeats.
  // Each instruction equals the memory word at its PC.
  // A stalled head stays stable, and no request is issued during a redirect.
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (imem_req_valid) begin
        total++;
        if (imem_addr !== exp_req_pc) $display("FAIL req_addr: got %h expected %h", imem_addr, exp_req_pc);
        else passed++;
      end
      if (redirect_valid) begin
        total++;
        if (imem_req_valid !== 1'b0) $display("FAIL req_during_redirect: got %b expected 0", imem_req_valid);
        else passed++;
      end
      if (!id_valid) begin
        total++;
        if (id_inst !== NOP || id_pc !== 32'h0) $display("FAIL idle_outputs: got %h/%h expected %h/0", id_inst, id_pc, NOP);
        else passed++;
      end
      if (hold_vld) begin
        total++;
        if (id_valid !== 1'b1 || id_inst !== hold_inst || id_pc !== hold_pc)
          $display("FAIL stall_hold: got %b %h/%h expected 1 %h/%h", id_valid, id_inst, id_pc, hold_inst, hold_pc);
        else passed++;
      end
      if (id_valid && id_ready) begin
        total++;
        if (id_pc !== exp_dec_pc) $display("FAIL decode_pc: got %h expected %h", id_pc, exp_dec_pc);
        else passed++;
        total++;
        if (id_inst !== mem_word(id_pc)) $display("FAIL decode_inst: got %h expected %h", id_inst, mem_word(id_pc));
        else passed++;
      end
      if (imem_req_valid && imem_req_ready) begin
        pend_addr.push_back(imem_addr);
        pend_due.push_back(cyc + 1 + (mem_fixed ? 0 : int'($urandom_range(0, 2))));
        exp_req_pc     = exp_req_pc + 32'd4;
        last_fire_addr = imem_addr;
        fire_cnt++;
      end
      if (id_valid && id_ready) begin
        exp_dec_pc  = exp_dec_pc + 32'd4;
        last_pop_pc = id_pc;
        pop_cnt++;
      end
      if (redirect_valid) begin
        exp_req_pc = {redirect_pc[31:2], 2'b00};
        exp_dec_pc = {redirect_pc[31:2], 2'b00};
      end
      hold_vld  = id_valid && !id_ready && !redirect_valid;
      hold_inst = id_inst;
      hold_pc   = id_pc;
      cyc++;
    end
  end

  task automatic mem_drive();
    imem_resp_valid = 1'b0;
    imem_resp_data  = $urandom;
    if (!mem_hold && pend_addr.size() > 0 && cyc >= pend_due[0] && (mem_fixed || $urandom_range(0, 3) != 0)) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
  endtask

  task automatic tick();
    mem_drive();
    @(posedge clk); #1;
  endtask

  task automatic clear_model();
    pend_addr.delete();
    pend_due.delete();
    exp_req_pc = RESET_PC;
    exp_dec_pc = RESET_PC;
    hold_vld   = 1'b0;
    mem_hold   = 1'b0;
    mem_fixed  = 1'b1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
    clear_model();
    @(posedge clk); @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
    clear_model();
    rstn = 1'b1; #1; rstn = 1'b0; #1;
    total++; if (imem_req_valid !== 1'b0) $display("FAIL rst_req_valid: got %b expected 0", imem_req_valid); else passed++;
    total++; if (id_valid !== 1'b0) $display("FAIL rst_id_valid: got %b expected 0", id_valid); else passed++;
    total++; if (id_inst !== NOP) $display("FAIL rst_id_inst: got %h expected %h", id_inst, NOP); else passed++;
    total++; if (id_pc !== 32'h0) $display("FAIL rst_id_pc: got %h expected 0", id_pc); else passed++;
    total++; if (imem_addr !== RESET_PC) $display("FAIL rst_addr: got %h expected %h", imem_addr, RESET_PC); else passed++;
    @(posedge clk); @(posedge clk); #1;
    rstn = 1'b1;
    #1;
    total++; if (imem_req_valid !== 1'b1) $display("FAIL post_rst_req: got %b expected 1", imem_req_valid); else passed++;
    repeat (3) tick();
    total++; if (imem_addr !== RESET_PC) $display("FAIL backpressure_addr: got %h expected %h", imem_addr, RESET_PC); else passed++;
  endtask

  task automatic test_stream();
    int p0;
    do_reset();
    imem_req_ready = 1'b1; id_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (k == 0) begin
        total++;
        if (imem_req_valid !== 1'b1 || imem_addr !== RESET_PC) $display("FAIL stream_first_req: got %b %h expected 1 %h", imem_req_valid, imem_addr, RESET_PC);
        else passed++;
      end else begin
        total++;
        if (id_valid !== (k == 2)) $display("FAIL stream_first_valid_k%0d: got %b expected %b", k, id_valid, (k == 2));
        else passed++;
      end
      tick();
    end
    p0 = pop_cnt;
    repeat (20) tick();
    total++;
    if (pop_cnt - p0 < 8) $display("FAIL stream_throughput: got %0d pops expected >= 8", pop_cnt - p0);
    else passed++;
  endtask

  task automatic test_stall();
    int f0, p0;
    do_reset();
    imem_req_ready = 1'b1; id_ready = 1'b0;
    f0 = fire_cnt;
    repeat (10) tick();
    #1;
    total++; if (fire_cnt - f0 != 2) $display("FAIL stall_fires: got %0d expected 2", fire_cnt - f0); else passed++;
    total++; if (imem_req_valid !== 1'b0) $display("FAIL stall_req_valid: got %b expected 0", imem_req_valid); else passed++;
    total++; if (imem_addr !== 32'h8) $display("FAIL stall_addr: got %h expected 00000008", imem_addr); else passed++;
    total++; if (id_valid !== 1'b1 || id_pc !== 32'h0) $display("FAIL stall_head: got %b %h expected 1 00000000", id_valid, id_pc); else passed++;
    id_ready = 1'b1;
    p0 = pop_cnt;
    for (int k = 0; k < 40 && pop_cnt - p0 < 4; k++) tick();
    total++;
    if (pop_cnt - p0 < 4 || last_pop_pc !== 32'hC) $display("FAIL stall_resume: got %0d pops last %h expected 4 pops last 0000000c", pop_cnt - p0, last_pop_pc);
    else passed++;
  endtask

  task automatic test_redirect();
    int p0;
    do_reset();
    mem_hold = 1'b1; imem_req_ready = 1'b1; id_ready = 1'b1;
    tick(); tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    redirect_valid = 1'b0;
    #1;
    total++; if (imem_addr !== 32'h100) $display("FAIL redir_addr: got %h expected 00000100", imem_addr); else passed++;
    total++; if (imem_req_valid !== 1'b0) $display("FAIL redir_credit: got %b expected 0", imem_req_valid); else passed++;
    mem_hold = 1'b0;
    p0 = pop_cnt;
    for (int k = 0; k < 40 && pop_cnt == p0; k++) tick();
    total++;
    if (pop_cnt == p0 || last_pop_pc !== 32'h100) $display("FAIL redir_first_pc: got %h (pops %0d) expected 00000100", last_pop_pc, pop_cnt - p0);
    else passed++;
  endtask

  task automatic test_redirect_collide();
    int p0;
    do_reset();
    imem_req_ready = 1'b1; id_ready = 1'b0;
    tick(); tick();
    #1;
    total++; if (id_valid !== 1'b1 || id_pc !== 32'h0) $display("FAIL collide_setup: got %b %h expected 1 00000000", id_valid, id_pc); else passed++;
    id_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
    tick();
    redirect_valid = 1'b0;
    #1;
    total++; if (id_valid !== 1'b0) $display("FAIL collide_flush: got %b expected 0", id_valid); else passed++;
    total++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h40) $display("FAIL collide_drop_cnt: got %b %h expected 1 00000040", imem_req_valid, imem_addr);
    else passed++;
    p0 = pop_cnt;
    for (int k = 0; k < 40 && pop_cnt == p0; k++) tick();
    total++;
    if (pop_cnt == p0 || last_pop_pc !== 32'h40) $display("FAIL collide_first_pc: got %h expected 00000040", last_pop_pc);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int p0;
    do_reset();
    mem_hold = 1'b1; imem_req_ready = 1'b1; id_ready = 1'b1;
    tick(); tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    tick();
    redirect_pc = 32'h0000_0300;
    tick();
    redirect_valid = 1'b0;
    #1;
    total++; if (imem_addr !== 32'h300) $display("FAIL b2b_addr: got %h expected 00000300", imem_addr); else passed++;
    mem_hold = 1'b0;
    p0 = pop_cnt;
    for (int k = 0; k < 40 && pop_cnt == p0; k++) tick();
    total++;
    if (pop_cnt == p0 || last_pop_pc !== 32'h300) $display("FAIL b2b_first_pc: got %h expected 00000300", last_pop_pc);
    else passed++;
  endtask

  task automatic test_wrap();
    int f0, p0;
    do_reset();
    imem_req_ready = 1'b1; id_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect_valid = 1'b0;
    f0 = fire_cnt;
    for (int k = 0; k < 20 && fire_cnt == f0; k++) tick();
    total++; if (last_fire_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_fire: got %h expected fffffffc", last_fire_addr); else passed++;
    total++; if (imem_addr !== 32'h0) $display("FAIL wrap_addr: got %h expected 00000000", imem_addr); else passed++;
    p0 = pop_cnt;
    for (int k = 0; k < 40 && pop_cnt - p0 < 2; k++) tick();
    total++;
    if (pop_cnt - p0 < 2 || last_pop_pc !== 32'h0) $display("FAIL wrap_decode: got %h expected 00000000", last_pop_pc);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int p0;
    do_reset();
    mem_hold = 1'b1; imem_req_ready = 1'b1; id_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    tick();
    rstn = 1'b0;
    clear_model();
    mem_hold = 1'b1;
    @(posedge clk); #1;
    rstn = 1'b1;
    imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    imem_resp_valid = 1'b0;
    total++; if (id_valid !== 1'b0) $display("FAIL late_resp_valid: got %b expected 0", id_valid); else passed++;
    total++; if (id_inst !== NOP) $display("FAIL late_resp_inst: got %h expected %h", id_inst, NOP); else passed++;
    total++; if (imem_addr !== RESET_PC || imem_req_valid !== 1'b1) $display("FAIL late_resp_restart: got %b %h expected 1 %h", imem_req_valid, imem_addr, RESET_PC); else passed++;
    mem_hold = 1'b0; imem_req_ready = 1'b1;
    p0 = pop_cnt;
    for (int k = 0; k < 40 && pop_cnt - p0 < 2; k++) tick();
    total++;
    if (pop_cnt - p0 < 2 || last_pop_pc !== RESET_PC + 32'd4) $display("FAIL late_resp_stream: got %h expected %h", last_pop_pc, RESET_PC + 32'd4);
    else passed++;
  endtask

  task automatic test_random();
    int p0;
    do_reset();
    mem_fixed = 1'b0;
    p0 = pop_cnt;
    for (int k = 0; k < 600; k++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      id_ready       = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc    = $urandom;
      tick();
    end
    redirect_valid = 1'b0;
    total++;
    if (pop_cnt - p0 < 20) $display("FAIL random_progress: got %0d pops expected >= 20", pop_cnt - p0);
    else passed++;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_collide();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
